mmio_bus_fabric: RTL and testbench

//  Parametrised successor to the shared data bus that links the CPU to memory-mapped peripherals.

---
 rtl/mmio_bus_fabric_pkg.sv | 38 +++
 rtl/mmio_bus_fabric_if.sv | 57 +++++
 rtl/mmio_bus_fabric_addr_decode.sv | 42 ++++
 rtl/mmio_bus_fabric.sv | 187 ++++++++++++++++++
 tb/tb_mmio_bus_fabric.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_bus_fabric_pkg.sv
// ----------------------------------------------------------------------------
// mmio_bus_fabric_pkg
// Shared definitions for the MMIO bus fabric. It holds the FSM state
// encodings, the error cause codes, the default status register base, the
// width of the wait-state counter and helpers for the status word and the
// slot index width.
// Ports: none (package).
// ----------------------------------------------------------------------------
package mmio_bus_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_UNMAPPED   = 3'd1,
        CAUSE_TIMEOUT    = 3'd2,
        CAUSE_RWCONFLICT = 3'd3
    } cause_t;

    localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'hFF20_0F00;
    localparam int          CNT_W               = 8;

    // Layout of status word 0: {err_count[15:0], 13'b0, last_cause[2:0]}.
    function automatic logic [31:0] status_word(input logic [15:0] count,
                                                input cause_t      cause);
        return {count, 13'b0, cause};
    endfunction

    // A single-slot fabric still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_bus_fabric_if.sv
// ----------------------------------------------------------------------------
// mmio_bus_fabric_if
// Bundles both sides of the fabric: the CPU data port (d_*) and the
// peripheral slot side (s_*).
//   slave  modport : the fabric's view. It takes CPU requests and slave
//                    responses, and drives CPU responses and slot strobes.
//   master modport : the environment's view (CPU plus peripherals). It uses
//                    the opposite directions.
// Signals:
//   d_address, d_write_data, d_byte_enable, d_read_enable, d_write_enable
//       request from the CPU
//   d_read_data, d_ready, d_error
//       registered completion back to the CPU
//   s_sel, s_address, s_write_data, s_byte_enable, s_read_enable,
//   s_write_enable
//       registered forward to the selected slot
//   s_read_data (flattened N_SLOTS*DATA_W), s_ready (one bit per slot)
//       responses from the slots
// ----------------------------------------------------------------------------
interface mmio_bus_fabric_if #(
    parameter int N_SLOTS = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
);
    logic [ADDR_W-1:0]         d_address;
    logic [DATA_W-1:0]         d_write_data;
    logic [DATA_W/8-1:0]       d_byte_enable;
    logic                      d_read_enable;
    logic                      d_write_enable;
    logic [DATA_W-1:0]         d_read_data;
    logic                      d_ready;
    logic                      d_error;

    logic [N_SLOTS-1:0]        s_sel;
    logic [ADDR_W-1:0]         s_address;
    logic [DATA_W-1:0]         s_write_data;
    logic [DATA_W/8-1:0]       s_byte_enable;
    logic                      s_read_enable;
    logic                      s_write_enable;
    logic [N_SLOTS*DATA_W-1:0] s_read_data;
    logic [N_SLOTS-1:0]        s_ready;

    modport slave (
        input  d_address, d_write_data, d_byte_enable, d_read_enable, d_write_enable,
        output d_read_data, d_ready, d_error,
        output s_sel, s_address, s_write_data, s_byte_enable, s_read_enable, s_write_enable,
        input  s_read_data, s_ready
    );

    modport master (
        output d_address, d_write_data, d_byte_enable, d_read_enable, d_write_enable,
        input  d_read_data, d_ready, d_error,
        input  s_sel, s_address, s_write_data, s_byte_enable, s_read_enable, s_write_enable,
        output s_read_data, s_ready
    );

endinterface

// File: rtl/mmio_bus_fabric_addr_decode.sv
// ----------------------------------------------------------------------------
// mmio_addr_decode
// Combinational priority decoder. Slot k matches when
// (address & mask_k) == base_k. When windows overlap, the lowest index wins.
// Ports:
//   address  in   ADDR_W    address to decode
//   hit      out  1         some slot matched
//   index    out  IDX_W     binary index of the winning slot
//   onehot   out  N_SLOTS   one-hot form of the winning slot
// ----------------------------------------------------------------------------
module mmio_addr_decode
    import mmio_bus_fabric_pkg::*;
#(
    parameter int                          N_SLOTS   = 8,
    parameter int                          ADDR_W    = 32,
    parameter int                          IDX_W     = idx_width(N_SLOTS),
    parameter logic [N_SLOTS*ADDR_W-1:0]   SLOT_BASE = '1,
    parameter logic [N_SLOTS*ADDR_W-1:0]   SLOT_MASK = '0
) (
    input  logic [ADDR_W-1:0]  address,
    output logic               hit,
    output logic [IDX_W-1:0]   index,
    output logic [N_SLOTS-1:0] onehot
);

    // The scan runs from the top slot down, so a lower matching slot
    // overwrites a higher one and ends up winning.
    always_comb begin
        hit    = 1'b0;
        index  = '0;
        onehot = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if ((address & SLOT_MASK[k*ADDR_W +: ADDR_W]) == SLOT_BASE[k*ADDR_W +: ADDR_W]) begin
                hit       = 1'b1;
                index     = IDX_W'(k);
                onehot    = '0;
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_fabric.sv
// ----------------------------------------------------------------------------
// mmio_bus_fabric
// Links the CPU data port to N memory-mapped slave slots. It provides:
//   - address decode into the slots;
//   - a registered read-data mux;
//   - a ready/wait-state handshake with a timeout;
//   - error capture, exposed as two status words at STATUS_ADDR and
//     STATUS_ADDR+4.
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous reset, active low
//   bus    slave modport of mmio_bus_fabric_if (CPU side and slot side)
// ----------------------------------------------------------------------------
module mmio_bus_fabric
    import mmio_bus_fabric_pkg::*;
#(
    parameter int                        N_SLOTS     = 8,
    parameter int                        DATA_W      = 32,
    parameter int                        ADDR_W      = 32,
    parameter logic [N_SLOTS*ADDR_W-1:0] SLOT_BASE   = '1,
    parameter logic [N_SLOTS*ADDR_W-1:0] SLOT_MASK   = '0,
    parameter int                        TIMEOUT     = 255,
    parameter logic [ADDR_W-1:0]         STATUS_ADDR = ADDR_W'(DEFAULT_STATUS_ADDR)
) (
    input  logic               clk,
    input  logic               rst_n,
    mmio_bus_fabric_if.slave   bus
);

    localparam int               IDX_W          = idx_width(N_SLOTS);
    localparam logic [ADDR_W-1:0] STATUS_ADDR_HI = STATUS_ADDR + ADDR_W'(4);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT    = CNT_W'(TIMEOUT);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]   sel_idx;
    logic [15:0]        err_count;
    cause_t             last_cause;
    logic [ADDR_W-1:0]  last_err_addr;

    logic               dec_hit;
    logic [IDX_W-1:0]   dec_index;
    logic [N_SLOTS-1:0] dec_onehot;

    mmio_addr_decode #(
        .N_SLOTS   (N_SLOTS),
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK)
    ) u_decode (
        .address (bus.d_address),
        .hit     (dec_hit),
        .index   (dec_index),
        .onehot  (dec_onehot)
    );

    logic              req;
    logic              rw_conflict;
    logic              status_lo_hit;
    logic              status_hi_hit;
    logic              slot_ready;
    logic [15:0]       err_count_inc;
    logic [DATA_W-1:0] slot_rdata;

    assign req           = bus.d_read_enable | bus.d_write_enable;
    assign rw_conflict   = bus.d_read_enable & bus.d_write_enable;
    assign status_lo_hit = (bus.d_address == STATUS_ADDR);
    assign status_hi_hit = (bus.d_address == STATUS_ADDR_HI);
    // Masking with the registered one-hot select means a ready from any
    // slot other than the selected one has no effect.
    assign slot_ready    = |(bus.s_ready & bus.s_sel);
    assign slot_rdata    = bus.s_read_data[sel_idx*DATA_W +: DATA_W];
    assign err_count_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    // Access FSM. All CPU-facing and slot-facing outputs are registered here.
    // In ACCESS the checks run in this order: abort, then slave ready, then
    // timeout. A ready that arrives in the expiry cycle therefore still
    // completes the access successfully.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            wait_cnt           <= '0;
            sel_idx            <= '0;
            err_count          <= '0;
            last_cause         <= CAUSE_NONE;
            last_err_addr      <= '0;
            bus.d_read_data    <= '0;
            bus.d_ready        <= 1'b0;
            bus.d_error        <= 1'b0;
            bus.s_sel          <= '0;
            bus.s_address      <= '0;
            bus.s_write_data   <= '0;
            bus.s_byte_enable  <= '0;
            bus.s_read_enable  <= 1'b0;
            bus.s_write_enable <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (rw_conflict || !(status_lo_hit || status_hi_hit || dec_hit)) begin
                            state           <= ST_DONE;
                            bus.d_ready     <= 1'b1;
                            bus.d_error     <= 1'b1;
                            bus.d_read_data <= '0;
                            err_count       <= err_count_inc;
                            last_err_addr   <= bus.d_address;
                            if (rw_conflict) begin
                                last_cause <= CAUSE_RWCONFLICT;
                            end else begin
                                last_cause <= CAUSE_UNMAPPED;
                            end
                        end else if (status_lo_hit || status_hi_hit) begin
                            // Status words shadow any slot window that also
                            // covers them.
                            state       <= ST_DONE;
                            bus.d_ready <= 1'b1;
                            bus.d_error <= 1'b0;
                            if (bus.d_write_enable) begin
                                bus.d_read_data <= '0;
                                if (status_lo_hit) begin
                                    err_count  <= '0;
                                    last_cause <= CAUSE_NONE;
                                end
                            end else if (status_lo_hit) begin
                                bus.d_read_data <= DATA_W'(status_word(err_count, last_cause));
                            end else begin
                                bus.d_read_data <= DATA_W'(last_err_addr);
                            end
                        end else begin
                            state              <= ST_ACCESS;
                            wait_cnt           <= '0;
                            sel_idx            <= dec_index;
                            bus.s_sel          <= dec_onehot;
                            bus.s_address      <= bus.d_address;
                            bus.s_write_data   <= bus.d_write_data;
                            bus.s_byte_enable  <= bus.d_byte_enable;
                            bus.s_read_enable  <= bus.d_read_enable;
                            bus.s_write_enable <= bus.d_write_enable;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (!req) begin
                        state              <= ST_IDLE;
                        bus.s_sel          <= '0;
                        bus.s_read_enable  <= 1'b0;
                        bus.s_write_enable <= 1'b0;
                    end else if (slot_ready) begin
                        state              <= ST_DONE;
                        bus.d_ready        <= 1'b1;
                        bus.d_error        <= 1'b0;
                        bus.d_read_data    <= bus.s_read_enable ? slot_rdata : '0;
                        bus.s_sel          <= '0;
                        bus.s_read_enable  <= 1'b0;
                        bus.s_write_enable <= 1'b0;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state              <= ST_DONE;
                        bus.d_ready        <= 1'b1;
                        bus.d_error        <= 1'b1;
                        bus.d_read_data    <= '0;
                        bus.s_sel          <= '0;
                        bus.s_read_enable  <= 1'b0;
                        bus.s_write_enable <= 1'b0;
                        err_count          <= err_count_inc;
                        last_cause         <= CAUSE_TIMEOUT;
                        last_err_addr      <= bus.s_address;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state       <= ST_IDLE;
                    bus.d_ready <= 1'b0;
                    bus.d_error <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// ----------------------------------------------------------------------------
// tb_mmio_bus_fabric
// Directed testbench for mmio_bus_fabric with eight slots and TIMEOUT=4.
// Slot map:
//   slot 0 : 1000_0xxx
//   slot 1 : 2000_xxxx
//   slot 2 : FF20_00xx
//   slot 3 : FF20_00xx (overlaps slot 2)
//   slot 5 : FF20_xxxx (covers the status words)
//   all other slots are unmapped.
// Ports: none.
// ----------------------------------------------------------------------------
module tb_mmio_bus_fabric;
    import mmio_bus_fabric_pkg::*;

    localparam logic [8*32-1:0] BASES = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFF20_0000, 32'hFFFF_FFFF,
                                         32'hFF20_0000, 32'hFF20_0000, 32'h2000_0000, 32'h1000_0000};
    localparam logic [8*32-1:0] MASKS = {32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000,
                                         32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_F000};
    localparam logic [31:0] STAT0 = 32'hFF20_0F00;
    localparam logic [31:0] STAT1 = 32'hFF20_0F04;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mmio_bus_fabric_if #(.N_SLOTS(8), .DATA_W(32), .ADDR_W(32)) bus ();

    mmio_bus_fabric #(
        .N_SLOTS     (8),
        .DATA_W      (32),
        .ADDR_W      (32),
        .SLOT_BASE   (BASES),
        .SLOT_MASK   (MASKS),
        .TIMEOUT     (4),
        .STATUS_ADDR (STAT0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Full CPU transaction with a bounded wait for d_ready.
    task automatic do_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output logic ok);
        ok    = 1'b0;
        err   = 1'b0;
        rdata = '0;
        @(negedge clk);
        bus.d_address      = addr;
        bus.d_write_data   = wdata;
        bus.d_byte_enable  = 4'hF;
        bus.d_read_enable  = !wr;
        bus.d_write_enable = wr;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.d_ready) begin
                ok    = 1'b1;
                rdata = bus.d_read_data;
                err   = bus.d_error;
            end
        end
        @(negedge clk);
        bus.d_read_enable  = 1'b0;
        bus.d_write_enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n              = 1'b1;
        bus.d_address      = '0;
        bus.d_write_data   = '0;
        bus.d_byte_enable  = '0;
        bus.d_read_enable  = 1'b0;
        bus.d_write_enable = 1'b0;
        bus.s_ready        = '0;
        for (int k = 0; k < 8; k++) bus.s_read_data[k*32 +: 32] = 32'hDEAD_0000 + k;
        bus.s_read_data[2*32 +: 32] = 32'hCAFE_F00D;
        #1 rst_n = 1'b0;
        #3;
        total++;
        if ({bus.d_ready, bus.d_error, bus.s_sel, bus.s_read_enable, bus.s_write_enable} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %h want 000",
                     {bus.d_ready, bus.d_error, bus.s_sel, bus.s_read_enable, bus.s_write_enable});
        end
        total++;
        if (bus.d_read_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_rdata: got %h want 00000000", bus.d_read_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.d_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle: got %b want 0", bus.d_ready);
        end
    endtask

    task automatic test_read_zero_wait();
        @(negedge clk);
        bus.s_ready       = 8'hFF;
        bus.d_address     = 32'hFF20_0010;
        bus.d_read_enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.s_sel !== 8'h04) begin
            bad++;
            $display("[TB] FAIL rd_sel: got %h want 04", bus.s_sel);
        end
        total++;
        if ({bus.s_read_enable, bus.s_write_enable, bus.d_ready, bus.s_address} !== {3'b100, 32'hFF20_0010}) begin
            bad++;
            $display("[TB] FAIL rd_fwd: got %b %b %b %h want 1 0 0 ff200010",
                     bus.s_read_enable, bus.s_write_enable, bus.d_ready, bus.s_address);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.d_ready, bus.d_error, bus.s_sel} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("[TB] FAIL rd_done: got %b %b %h want 1 0 00", bus.d_ready, bus.d_error, bus.s_sel);
        end
        total++;
        if (bus.d_read_data !== 32'hCAFE_F00D) begin
            bad++;
            $display("[TB] FAIL rd_data: got %h want cafef00d", bus.d_read_data);
        end
        @(negedge clk) bus.d_read_enable = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.d_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rd_one_cycle: got %b want 0", bus.d_ready);
        end
        @(negedge clk) bus.s_ready = 8'h00;
    endtask

    // Write with the slot answering in its fifth ACCESS cycle, which is also
    // the timeout expiry cycle; ready from other slots is held high meanwhile.
    task automatic test_write_wait();
        @(negedge clk);
        bus.s_ready        = 8'hFE;
        bus.d_address      = 32'h1000_0040;
        bus.d_write_data   = 32'h1111_2222;
        bus.d_byte_enable  = 4'b0011;
        bus.d_write_enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.s_write_data, bus.s_byte_enable} !== {32'h1111_2222, 4'b0011}) begin
            bad++;
            $display("[TB] FAIL wr_fwd: got %h %b want 11112222 0011", bus.s_write_data, bus.s_byte_enable);
        end
        for (int k = 1; k <= 5; k++) begin
            total++;
            if ({bus.s_sel, bus.s_write_enable, bus.d_ready} !== {8'h01, 1'b1, 1'b0}) begin
                bad++;
                $display("[TB] FAIL wr_hold_c%0d: got %h %b %b want 01 1 0",
                         k, bus.s_sel, bus.s_write_enable, bus.d_ready);
            end
            if (k == 5) begin
                @(negedge clk) bus.s_ready = 8'hFF;
            end
            @(posedge clk); #1;
        end
        total++;
        if ({bus.d_ready, bus.d_error, bus.s_sel, bus.s_write_enable} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("[TB] FAIL wr_done: got %b %b %h %b want 1 0 00 0",
                     bus.d_ready, bus.d_error, bus.s_sel, bus.s_write_enable);
        end
        total++;
        if (bus.d_read_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL wr_rdata: got %h want 00000000", bus.d_read_data);
        end
        @(negedge clk);
        bus.d_write_enable = 1'b0;
        bus.s_ready        = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        @(negedge clk);
        bus.s_ready       = 8'hFD;
        bus.d_address     = 32'h2000_0100;
        bus.d_read_enable = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            total++;
            if ({bus.s_sel, bus.d_ready} !== {8'h02, 1'b0}) begin
                bad++;
                $display("[TB] FAIL to_wait_c%0d: got %h %b want 02 0", k, bus.s_sel, bus.d_ready);
            end
            @(posedge clk); #1;
        end
        total++;
        if ({bus.d_ready, bus.d_error, bus.s_sel, bus.d_read_data} !== {1'b1, 1'b1, 8'h00, 32'h0}) begin
            bad++;
            $display("[TB] FAIL to_err: got %b %b %h %h want 1 1 00 00000000",
                     bus.d_ready, bus.d_error, bus.s_sel, bus.d_read_data);
        end
        @(negedge clk);
        bus.d_read_enable = 1'b0;
        bus.s_ready       = 8'hFF;
        @(posedge clk); #1;
        total++;
        if ({bus.d_ready, bus.d_error} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL to_late_ready: got %b %b want 0 0", bus.d_ready, bus.d_error);
        end
        @(negedge clk) bus.s_ready = 8'h00;
        do_access(STAT0, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0001_0002}) begin
            bad++;
            $display("[TB] FAIL to_status0: got %b %b %h want 1 0 00010002", ok, er, rd);
        end
        do_access(STAT1, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h2000_0100}) begin
            bad++;
            $display("[TB] FAIL to_status1: got %b %b %h want 1 0 20000100", ok, er, rd);
        end
    endtask

    task automatic test_unmapped_status();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        @(negedge clk);
        bus.d_address     = 32'h1234_5678;
        bus.d_read_enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.d_ready, bus.d_error, bus.s_sel, bus.s_read_enable} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            bad++;
            $display("[TB] FAIL um_err: got %b %b %h %b want 1 1 00 0",
                     bus.d_ready, bus.d_error, bus.s_sel, bus.s_read_enable);
        end
        @(negedge clk) bus.d_read_enable = 1'b0;
        @(posedge clk); #1;
        do_access(STAT0, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0002_0001}) begin
            bad++;
            $display("[TB] FAIL um_status0: got %b %b %h want 1 0 00020001", ok, er, rd);
        end
        do_access(STAT1, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            bad++;
            $display("[TB] FAIL um_status1: got %b %b %h want 1 0 12345678", ok, er, rd);
        end
        do_access(STAT0, 1'b1, 32'hFFFF_FFFF, rd, er, ok);
        total++;
        if ({ok, er} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL um_clear_wr: got %b %b want 1 0", ok, er);
        end
        do_access(STAT1, 1'b1, 32'h5555_5555, rd, er, ok);
        do_access(STAT0, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0000_0000}) begin
            bad++;
            $display("[TB] FAIL um_cleared: got %b %b %h want 1 0 00000000", ok, er, rd);
        end
        do_access(STAT1, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            bad++;
            $display("[TB] FAIL um_addr_kept: got %b %b %h want 1 0 12345678", ok, er, rd);
        end
    endtask

    task automatic test_conflict_abort();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        logic        seen;
        @(negedge clk);
        bus.s_ready        = 8'hFF;
        bus.d_address      = 32'hFF20_0010;
        bus.d_read_enable  = 1'b1;
        bus.d_write_enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.d_ready, bus.d_error, bus.s_sel, bus.s_read_enable, bus.s_write_enable}
                !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL rw_err: got %b %b %h %b %b want 1 1 00 0 0",
                     bus.d_ready, bus.d_error, bus.s_sel, bus.s_read_enable, bus.s_write_enable);
        end
        @(negedge clk);
        bus.d_read_enable  = 1'b0;
        bus.d_write_enable = 1'b0;
        bus.s_ready        = 8'h00;
        @(posedge clk); #1;
        do_access(STAT0, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0001_0003}) begin
            bad++;
            $display("[TB] FAIL rw_status: got %b %b %h want 1 0 00010003", ok, er, rd);
        end
        @(negedge clk);
        bus.d_address     = 32'h2000_0200;
        bus.d_read_enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.s_sel !== 8'h02) begin
            bad++;
            $display("[TB] FAIL ab_sel: got %h want 02", bus.s_sel);
        end
        @(negedge clk) bus.d_read_enable = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus.s_sel, bus.s_read_enable, bus.d_ready} !== {8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL ab_drop: got %h %b %b want 00 0 0", bus.s_sel, bus.s_read_enable, bus.d_ready);
        end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | bus.d_ready;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ab_no_ready: got %b want 0", seen);
        end
        do_access(STAT0, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0001_0003}) begin
            bad++;
            $display("[TB] FAIL ab_status: got %b %b %h want 1 0 00010003", ok, er, rd);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic        er;
        logic        ok;
        @(negedge clk);
        bus.s_ready       = 8'h00;
        bus.d_address     = 32'h2000_0300;
        bus.d_read_enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.s_sel !== 8'h02) begin
            bad++;
            $display("[TB] FAIL ar_sel: got %h want 02", bus.s_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.s_sel, bus.s_read_enable, bus.d_ready, bus.d_error} !== 11'h000) begin
            bad++;
            $display("[TB] FAIL ar_clear: got %h %b %b %b want 00 0 0 0",
                     bus.s_sel, bus.s_read_enable, bus.d_ready, bus.d_error);
        end
        bus.d_read_enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        bus.s_ready = 8'hFF;
        do_access(32'hFF20_0010, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            bad++;
            $display("[TB] FAIL ar_fresh_read: got %b %b %h want 1 0 cafef00d", ok, er, rd);
        end
        bus.s_ready = 8'h00;
        do_access(STAT0, 1'b0, 32'h0, rd, er, ok);
        total++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0000_0000}) begin
            bad++;
            $display("[TB] FAIL ar_status: got %b %b %h want 1 0 00000000", ok, er, rd);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_timeout();
        test_unmapped_status();
        test_conflict_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
